pipe_field: RTL and testbench

Upstream playfield generator for the 16x16 Flappy Bird matrix. It produces the scrolling pipe pattern on `green[15:0][15:0]`, which feeds the score stage and the LED driver. It also detects bird/pipe overlap and drives the `collision` input of the HEX counter. Pipes enter at column 0 and move one column per scroll step toward column 15, where the bird sits and scoring is sampled.

---
 rtl/pipe_field.sv | 97 +++++++++
 tb/tb_pipe_field.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
// Scrolling pipe playfield for the 16x16 Flappy Bird matrix, with a sticky
// bird/pipe collision flag and a one-cycle pulse on every scroll.
`timescale 1ns/1ps
module pipe_field #(
    parameter int          TICK_DIV     = 5_000_000,
    parameter int          PIPE_SPACING = 6,
    parameter int          GAP_H        = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [3:0]        bird_y,
    output logic [15:0][15:0] green,
    output logic              collision,
    output logic              step
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(PIPE_SPACING);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPC_LAST  = SW'(PIPE_SPACING - 1);

    logic [TW-1:0]     tick_reg, tick_next;
    logic [SW-1:0]     spc_reg, spc_next;
    logic [15:0]       lfsr_reg, lfsr_next;
    logic [15:0][15:0] green_reg, green_next;
    logic [15:0][15:0] shifted;
    logic              collision_reg, collision_next;
    logic              step_reg;

    logic        run;
    logic        scroll;
    logic [4:0]  gap_top;
    logic [15:0] pipe_col;
    logic [15:0] new_col;

    assign run     = enable & ~collision_reg;
    assign scroll  = run & (tick_reg == TICK_LAST);
    assign gap_top = {2'b00, lfsr_reg[2:0]} + 5'd2;
    assign new_col = (spc_reg == '0) ? pipe_col : 16'h0000;

    // A row is dark only inside the gap window [gap_top, gap_top+GAP_H).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rows
            assign pipe_col[gi] = ~((5'(gi) >= gap_top) &&
                                    (5'(gi) <  gap_top + 5'(GAP_H)));
        end
    endgenerate

    // Columns move toward 15; the oldest column falls off the end.
    assign shifted[0] = new_col;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_shift
            assign shifted[gi] = green_reg[gi-1];
        end
    endgenerate

    always_comb begin
        tick_next      = tick_reg;
        spc_next       = spc_reg;
        lfsr_next      = lfsr_reg;
        green_next     = green_reg;
        collision_next = collision_reg | (enable & green_reg[15][bird_y]);
        if (run) begin
            tick_next = scroll ? '0 : tick_reg + TW'(1);
        end
        if (scroll) begin
            green_next = shifted;
            spc_next   = (spc_reg == SPC_LAST) ? '0 : spc_reg + SW'(1);
            lfsr_next  = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg      <= '0;
            spc_reg       <= '0;
            lfsr_reg      <= LFSR_SEED;
            green_reg     <= '0;
            collision_reg <= 1'b0;
            step_reg      <= 1'b0;
        end else begin
            tick_reg      <= tick_next;
            spc_reg       <= spc_next;
            lfsr_reg      <= lfsr_next;
            green_reg     <= green_next;
            collision_reg <= collision_next;
            step_reg      <= scroll;
        end
    end

    assign green     = green_reg;
    assign collision = collision_reg;
    assign step      = step_reg;

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field with a behavioural playfield model; every
// scroll's expected playfield is queued and popped when the DUT pulses step.
`timescale 1ns/1ps
module tb_pipe_field;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [3:0]        bird_y;
    logic [15:0][15:0] green;
    logic              collision;
    logic              step;

    pipe_field #(
        .TICK_DIV    (4),
        .PIPE_SPACING(6),
        .GAP_H       (4),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bird_y   (bird_y),
        .green    (green),
        .collision(collision),
        .step     (step)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0][15:0] m_green;
    logic [15:0]       m_lfsr;
    int                m_tick;
    int                m_spc;
    int                m_steps;
    logic              m_coll;
    logic              m_step;
    logic [15:0][15:0] exp_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pipe_of(input logic [15:0] l);
        int gt;
        gt = 2 + int'(l[2:0]);
        return ~(16'h000F << gt);
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare the DUT shortly after.
    task automatic cyc();
        logic              run;
        logic              nc;
        logic [15:0][15:0] popped;
        @(posedge clk);
        if (rst) begin
            m_green = '0; m_coll = 1'b0; m_tick = 0; m_spc = 0;
            m_lfsr = 16'hACE1; m_step = 1'b0; m_steps = 0;
        end else begin
            run    = enable && !m_coll;
            nc     = m_coll || (enable && m_green[15][bird_y]);
            m_step = 1'b0;
            if (run) begin
                if (m_tick == 3) begin
                    for (int c = 15; c >= 1; c--) m_green[c] = m_green[c-1];
                    m_green[0] = (m_spc == 0) ? pipe_of(m_lfsr) : 16'h0000;
                    m_spc   = (m_spc + 1) % 6;
                    m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
                    m_tick  = 0;
                    m_step  = 1'b1;
                    m_steps++;
                    exp_q.push_back(m_green);
                end else begin
                    m_tick++;
                end
            end
            m_coll = nc;
        end
        #1;
        chk("step", step, m_step);
        chk("collision", collision, m_coll);
        chk("green", green, m_green);
        if (step === 1'b1) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                chk("sb_green", green, popped);
            end
        end
    endtask

    task automatic wait_steps(input int target);
        int guard;
        guard = 0;
        while (m_steps < target && guard < 400) begin
            cyc();
            guard++;
        end
        chk("wait_steps_bound", m_steps >= target, 1'b1);
    endtask

    initial begin
        logic [15:0][15:0] snap;
        int                n;
        m_green = '0; m_coll = 1'b0; m_tick = 0; m_spc = 0;
        m_lfsr = 16'hACE1; m_step = 1'b0; m_steps = 0;
        rst = 1'b1; enable = 1'b1; bird_y = 4'd4;

        // Reset held with enable high
        repeat (3) cyc();
        chk("rst_green", green, '0);
        chk("rst_collision", collision, 1'b0);
        rst = 1'b0;

        // First spawn on the 4th edge
        repeat (3) cyc();
        chk("pre_first_step", step, 1'b0);
        cyc();
        chk("first_step", step, 1'b1);
        chk("first_pipe", green[0], 16'hFF87);
        snap = green; snap[0] = 16'h0000;
        chk("first_others_zero", snap, '0);

        // Spacing: second pipe at step 7
        wait_steps(7);
        chk("spc_col6", green[6], 16'hFF87);
        chk("spc_gap_edges", {green[0][15:13], green[0][1:0]}, 5'b11111);
        chk("spc_popcount", $countones(green[0]), 12);
        snap = green; snap[0] = 16'h0000; snap[6] = 16'h0000;
        chk("spc_others_zero", snap, '0);

        // Freeze mid-period, then resume with the remaining ticks
        repeat (2) cyc();
        snap = green;
        enable = 1'b0;
        repeat (10) cyc();
        chk("freeze_green", green, snap);
        enable = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (step !== 1'b1 && n < 20);
        chk("resume_latency", n, 2);

        // Collision with bird at row 0
        bird_y = 4'd0;
        wait_steps(16);
        chk("col15_pipe", green[15], 16'hFF87);
        chk("coll_not_yet", collision, 1'b0);
        cyc();
        chk("coll_rise", collision, 1'b1);
        snap = green;
        repeat (12) cyc();
        chk("coll_frozen", green, snap);
        chk("coll_row14", green[15][14], 1'b1);

        // Reset after collision, reseeded LFSR, bird in the gap
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_green", green, '0);
        chk("rst2_collision", collision, 1'b0);
        bird_y = 4'd4;
        wait_steps(1);
        chk("reseed_pipe", green[0], 16'hFF87);
        wait_steps(16);
        chk("gap_col15", green[15], 16'hFF87);
        wait_steps(21);
        repeat (3) cyc();
        chk("gap_no_collision", collision, 1'b0);

        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
